alu_share_arbiter: RTL and testbench

// - Shares the single 32-bit ALU and its NOR-reduced zero flag between two requesters
//   (e.g. the main datapath and the branch-compare unit).
// - Arbitrates the requests, drives the ALU operands and opcode from registers,

---
 rtl/alu_share_arbiter_if.sv | 27 ++
 rtl/alu_share_arbiter.sv | 109 ++++++++++
 tb/tb_alu_share_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arbiter.
// master = requester/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
);
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [2*OPW-1:0]   req_op;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [WIDTH-1:0]   rsp_data;
   logic               rsp_zero;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_share_arbiter_if.slave    bus,
   output logic [OPW-1:0]        alu_op,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   input  logic [WIDTH-1:0]      alu_res,
   input  logic                  alu_zero,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_reg, state_next;
   logic [OPW-1:0]     alu_op_reg;
   logic [WIDTH-1:0]   alu_a_reg, alu_b_reg;
   logic               rsp_id_reg;
   logic [WIDTH-1:0]   rsp_data_reg;
   logic               rsp_zero_reg;
   logic               grant;
   logic               accept;
   logic [1:0]         ready_onehot;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic               last_grant_reg;
`endif

   logic [OPW-1:0]     op_arr [2];
   logic [WIDTH-1:0]   a_arr  [2];
   logic [WIDTH-1:0]   b_arr  [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_split
      assign op_arr[gi] = bus.req_op[OPW*gi +: OPW];
      assign a_arr[gi]  = bus.req_a[WIDTH*gi +: WIDTH];
      assign b_arr[gi]  = bus.req_b[WIDTH*gi +: WIDTH];
   end

   always_comb begin
      state_next   = state_reg;
      accept       = 1'b0;
      ready_onehot = 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = ~bus.req_valid[0];
`else
      // On a tie the requester that did not win last time goes next.
      if (&bus.req_valid)
         grant = ~last_grant_reg;
      else
         grant = bus.req_valid[1];
`endif
      case (state_reg)
         IDLE: begin
            if (|bus.req_valid) begin
               accept       = 1'b1;
               ready_onehot = grant ? 2'b10 : 2'b01;
               state_next   = EXEC;
            end
         end
         EXEC:    state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         alu_op_reg   <= '0;
         alu_a_reg    <= '0;
         alu_b_reg    <= '0;
         rsp_id_reg   <= 1'b0;
         rsp_data_reg <= '0;
         rsp_zero_reg <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant_reg <= 1'b1;
`endif
      end else begin
         state_reg <= state_next;
         if (accept) begin
            alu_op_reg <= op_arr[grant];
            alu_a_reg  <= a_arr[grant];
            alu_b_reg  <= b_arr[grant];
            rsp_id_reg <= grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_reg <= grant;
`endif
         end
         // ALU inputs have been stable since the accept edge, so the result is settled here.
         if (state_reg == EXEC) begin
            rsp_data_reg <= alu_res;
            rsp_zero_reg <= alu_zero;
         end
      end
   end

   assign bus.req_ready = ready_onehot;
   assign bus.rsp_valid = (state_reg == RESP);
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_zero  = rsp_zero_reg;
   assign alu_op        = alu_op_reg;
   assign alu_a         = alu_a_reg;
   assign alu_b         = alu_b_reg;
   assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR).
module tb_alu_share_arbiter;
   localparam int WIDTH = 32;
   localparam int OPW   = 3;
   localparam logic [OPW-1:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_XOR = 3'd4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus();

   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_res;
   logic             alu_zero, busy;

   alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_res  (alu_res),
      .alu_zero (alu_zero),
      .busy     (busy)
   );

   always_comb begin
      alu_res = '0;
      case (alu_op)
         OP_ADD:  alu_res = alu_a + alu_b;
         OP_SUB:  alu_res = alu_a - alu_b;
         OP_AND:  alu_res = alu_a & alu_b;
         OP_OR:   alu_res = alu_a | alu_b;
         OP_XOR:  alu_res = alu_a ^ alu_b;
         default: alu_res = '0;
      endcase
   end
   assign alu_zero = ~|alu_res;

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] data;
      logic             zero;
   } rsp_t;

   rsp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_req_ready"}, {30'd0, bus.req_ready}, 0);
      chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 0);
      chk({tag, "_rsp_id"},    {31'd0, bus.rsp_id}, 0);
      chk({tag, "_rsp_data"},  bus.rsp_data, 0);
      chk({tag, "_rsp_zero"},  {31'd0, bus.rsp_zero}, 0);
      chk({tag, "_alu_op"},    {29'd0, alu_op}, 0);
      chk({tag, "_alu_a"},     alu_a, 0);
      chk({tag, "_alu_b"},     alu_b, 0);
      chk({tag, "_busy"},      {31'd0, busy}, 0);
   endtask

   // Monitor: every response handshake pops one expectation.
   always @(negedge clk) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
         rsp_t e;
         $display("rsp id=%0d data=0x%08h zero=%0d", bus.rsp_id, bus.rsp_data, bus.rsp_zero);
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: got id %0d data 0x%0h, expected no response", bus.rsp_id, bus.rsp_data);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id",   {31'd0, bus.rsp_id}, {31'd0, e.id});
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, e.zero});
            chk("rsp_zero_invariant", {31'd0, bus.rsp_zero}, {31'd0, (bus.rsp_data == '0)});
         end
      end
   end

   task automatic drive(input int id, input logic [OPW-1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.req_valid[id]            = 1'b1;
      bus.req_op[OPW*id +: OPW]    = op;
      bus.req_a[WIDTH*id +: WIDTH] = a;
      bus.req_b[WIDTH*id +: WIDTH] = b;
   endtask

   // Presents one request, waits (bounded) for its accept, optionally records the expected response.
   // Returns #1 after the accept edge, i.e. inside the EXEC cycle.
   task automatic issue(input int id, input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_d, input logic exp_z,
                        input bit expect_rsp);
      bit got = 1'b0;
      logic [1:0] want;
      want = (id == 1) ? 2'b10 : 2'b01;
      drive(id, op, a, b);
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready[id]) got = 1'b1;
      end
      chk("req_ready", {30'd0, bus.req_ready}, {30'd0, want});
      if (got && expect_rsp) exp_q.push_back(rsp_t'({id[0], exp_d, exp_z}));
      @(posedge clk);
      #1;
      bus.req_valid[id] = 1'b0;
   endtask

   // Burst stimulus: per requester op, a, b, expected result.
   logic [OPW-1:0]   r_op  [2][4];
   logic [WIDTH-1:0] r_a   [2][4];
   logic [WIDTH-1:0] r_b   [2][4];
   logic [WIDTH-1:0] r_exp [2][4];
   int               g_exp [4];

   initial begin
      int p [2];
      int n, last_acc, g;

      r_op[0] = '{OP_ADD, OP_AND, OP_XOR, OP_OR};
      r_a[0]  = '{32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h1234_5678, 32'h0000_000A};
      r_b[0]  = '{32'h0000_0001, 32'h0FF0_0FF0, 32'h1234_5678, 32'h0000_0005};
      r_exp[0] = '{32'h0000_0000, 32'h00F0_00F0, 32'h0000_0000, 32'h0000_000F};
      r_op[1] = '{OP_SUB, OP_ADD, OP_SUB, OP_AND};
      r_a[1]  = '{32'h0000_0000, 32'd100, 32'h8000_0000, 32'h0000_0000};
      r_b[1]  = '{32'h0000_0001, 32'd23, 32'h0000_0001, 32'h0000_FFFF};
      r_exp[1] = '{32'hFFFF_FFFF, 32'd123, 32'h7FFF_FFFF, 32'h0000_0000};
`ifdef ALU_ARB_FIXED_PRIO_EN
      g_exp = '{0, 0, 0, 0};
`else
      g_exp = '{0, 1, 0, 1};
`endif

      bus.req_valid = 2'b00;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_state("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // ADD 5+3 from requester 0, latency check
      issue(0, OP_ADD, 32'd5, 32'd3, 32'd8, 1'b0, 1'b1);
      @(negedge clk);
      chk("exec_rsp_valid", {31'd0, bus.rsp_valid}, 0);
      chk("exec_busy", {31'd0, busy}, 1);
      chk("exec_req_ready", {30'd0, bus.req_ready}, 0);
      @(negedge clk);
      chk("latency_rsp_valid", {31'd0, bus.rsp_valid}, 1);
      @(posedge clk);
      #1;

      // SUB 7-7 from requester 1 gives zero
      issue(1, OP_SUB, 32'd7, 32'd7, 32'd0, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;

      // Both requesters valid continuously
      p = '{0, 0};
      drive(0, r_op[0][0], r_a[0][0], r_b[0][0]);
      drive(1, r_op[1][0], r_a[1][0], r_b[1][0]);
      n = 0;
      last_acc = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk);
         if (bus.req_ready != 2'b00) begin
            g = int'(bus.req_ready[1]);
            chk("arb_grant", g, g_exp[n]);
            if (n > 0) chk("accept_gap", cyc - last_acc, 3);
            last_acc = cyc;
            exp_q.push_back(rsp_t'({g[0], r_exp[g][p[g]], (r_exp[g][p[g]] == '0)}));
            p[g]++;
            n++;
            @(posedge clk);
            #1;
            if (n == 4) bus.req_valid = 2'b00;
            else if (p[g] < 4) drive(g, r_op[g][p[g]], r_a[g][p[g]], r_b[g][p[g]]);
            else bus.req_valid[g] = 1'b0;
         end
      end
      chk("burst_accepts", n, 4);
      bus.req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1;

      // Response back-pressure with requester 1 waiting
      bus.rsp_ready = 1'b0;
      issue(0, OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b1);
      drive(1, OP_SUB, 32'd9, 32'd4);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 1);
         chk("stall_rsp_data", bus.rsp_data, 32'd4);
         chk("stall_rsp_id", {31'd0, bus.rsp_id}, 0);
         chk("stall_req_ready", {30'd0, bus.req_ready}, 0);
         chk("stall_busy", {31'd0, busy}, 1);
         if (i < 3) @(negedge clk);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_busy", {31'd0, busy}, 0);
      chk("release_req_ready", {30'd0, bus.req_ready}, 2);
      if (bus.req_ready[1]) exp_q.push_back(rsp_t'({1'b1, 32'd5, 1'b0}));
      @(posedge clk);
      #1 bus.req_valid = 2'b00;
      repeat (2) @(posedge clk);
      #1;

      // Reset pulse during EXEC discards the transaction
      issue(0, OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_state("midrst");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_rsp", {31'd0, bus.rsp_valid}, 0);
      end
      @(posedge clk);
      #1;
      issue(1, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);

      // Drain
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("drain_pending", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
